// File: rtl/sseg_scan_mux_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// sseg_scan_mux_if : display data / load handshake and scan outputs.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface sseg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] din;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load;
    logic [2:0]              brightness;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              sseg;
    logic                    dp;
    logic                    frame_start;
    logic                    load_ack;

    modport master (
        output din, dp_in, blank_in, load, brightness,
        input  an, sseg, dp, frame_start, load_ack
    );

    modport slave (
        input  din, dp_in, blank_in, load, brightness,
        output an, sseg, dp, frame_start, load_ack
    );
endinterface
`default_nettype wire

// File: rtl/sseg_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// sseg_scan_mux : multiplexed 7-segment scanner with frame-synchronous commit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sseg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 65536
) (
    input wire logic        clk,
    input wire logic        reset_n,
    sseg_scan_mux_if.slave  bus
);
    localparam int PRE_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int LIM_W = PRE_W + 4;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [LIM_W-1:0] EIGHTH   = LIM_W'(SLOT_CYCLES / 8);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] pend_din;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pending;

    logic [4*NUM_DIGITS-1:0] disp_din;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;

    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              sseg_q;
    logic                    dp_q;
    logic                    frame_start_q;
    logic                    load_ack_q;

    logic                    slot_end;
    logic                    frame_end;
    logic [LIM_W-1:0]        on_limit;
    logic                    on_window;
    logic [3:0]              cur_hex;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    lit;
    logic [6:0]              seg_code;

    assign slot_end  = (prescaler == PRE_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    // Window length in slot eighths; LIM_W leaves headroom for 8 * (SLOT_CYCLES/8).
    assign on_limit  = (LIM_W'(bus.brightness) + LIM_W'(1)) * EIGHTH;
    assign on_window = (LIM_W'(prescaler) < on_limit);

    always_comb begin
        cur_hex   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        onehot    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_hex   = disp_din[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_blank = disp_blank[k];
                onehot[k] = 1'b1;
            end
        end
    end

    assign lit = on_window && !cur_blank;

    always_comb begin
        seg_code = 7'b1111111;
        case (cur_hex)
            4'h0: seg_code = 7'b0000001;
            4'h1: seg_code = 7'b1001111;
            4'h2: seg_code = 7'b0010010;
            4'h3: seg_code = 7'b0000110;
            4'h4: seg_code = 7'b1001100;
            4'h5: seg_code = 7'b0100100;
            4'h6: seg_code = 7'b0100000;
            4'h7: seg_code = 7'b0001111;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0000100;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b1100000;
            4'hC: seg_code = 7'b0110001;
            4'hD: seg_code = 7'b1000010;
            4'hE: seg_code = 7'b0110000;
            4'hF: seg_code = 7'b0111000;
            default: seg_code = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else if (slot_end) begin
            prescaler <= '0;
            idx       <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Commit takes the old pending contents even when a load lands on the
    // same edge; that load then waits in pending for the next boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_din   <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            pending    <= 1'b0;
            disp_din   <= '0;
            disp_dp    <= '0;
            disp_blank <= '1;
        end else begin
            if (frame_end && pending) begin
                disp_din   <= pend_din;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
            end
            if (bus.load) begin
                pend_din   <= bus.din;
                pend_dp    <= bus.dp_in;
                pend_blank <= bus.blank_in;
                pending    <= 1'b1;
            end else if (frame_end) begin
                pending    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q          <= '1;
            sseg_q        <= 7'b1111111;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
        end else begin
            an_q          <= lit ? ~onehot : '1;
            sseg_q        <= lit ? seg_code : 7'b1111111;
            dp_q          <= lit ? ~cur_dp : 1'b1;
            frame_start_q <= (prescaler == '0) && (idx == '0);
            load_ack_q    <= frame_end && pending;
        end
    end

    assign bus.an          = an_q;
    assign bus.sseg        = sseg_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;
    assign bus.load_ack    = load_ack_q;
endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sseg_scan_mux : scoreboard bench for the 4-digit, 16-cycle-slot scanner.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sseg_scan_mux;
    localparam int ND = 4;
    localparam int SC = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sseg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    sseg_scan_mux #(.NUM_DIGITS(ND), .SLOT_CYCLES(SC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] n;
        logic [3:0]  an;
        logic [6:0]  sseg;
        logic        dp;
        logic        fs;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   fs_cnt, ack_cnt, dp_low_cnt;
    int   low_cnt[ND];
    logic [2:0] bright;

    int          m_n;
    logic        m_pending;
    logic [15:0] m_pend_din, m_disp_din;
    logic [3:0]  m_pend_dp, m_disp_dp, m_pend_blank, m_disp_blank;

    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: the scan outputs are presented every cycle, one entry per edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.an, bus.sseg, bus.dp, bus.frame_start, bus.load_ack} !==
                {e.an, e.sseg, e.dp, e.fs, e.ack}) begin
                errors++;
                $display("FAIL scan n=%0d: got an=%b sseg=%b dp=%b fs=%b ack=%b, required an=%b sseg=%b dp=%b fs=%b ack=%b",
                         e.n, bus.an, bus.sseg, bus.dp, bus.frame_start, bus.load_ack,
                         e.an, e.sseg, e.dp, e.fs, e.ack);
            end
            if (bus.frame_start) fs_cnt++;
            if (bus.load_ack) ack_cnt++;
            if (!bus.dp) dp_low_cnt++;
            for (int k = 0; k < ND; k++)
                if (!bus.an[k]) low_cnt[k]++;
        end
    end

    task automatic clear_counts();
        fs_cnt = 0;
        ack_cnt = 0;
        dp_low_cnt = 0;
        for (int k = 0; k < ND; k++) low_cnt[k] = 0;
    endtask

    task automatic model_reset();
        m_n          = 0;
        m_pending    = 1'b0;
        m_pend_din   = '0;
        m_disp_din   = '0;
        m_pend_dp    = '0;
        m_disp_dp    = '0;
        m_pend_blank = 4'hF;
        m_disp_blank = 4'hF;
    endtask

    task automatic push_dark();
        exp_t e;
        e.n = '0; e.an = 4'hF; e.sseg = 7'h7F; e.dp = 1'b1; e.fs = 1'b0; e.ack = 1'b0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Called at a falling edge: drives inputs for the next rising edge and
    // queues the output that edge must produce.
    task automatic cycle(input logic ld, input logic [15:0] d,
                         input logic [3:0] dpv, input logic [3:0] bl);
        int   pre, idx;
        logic lit, bnd;
        exp_t e;
        bus.load = ld; bus.din = d; bus.dp_in = dpv; bus.blank_in = bl;
        bus.brightness = bright;
        pre = m_n % SC;
        idx = (m_n / SC) % ND;
        bnd = (pre == SC - 1) && (idx == ND - 1);
        lit = (pre < (int'(bright) + 1) * (SC / 8)) && !m_disp_blank[idx];
        e.n    = 16'(m_n);
        e.an   = lit ? ~(4'b0001 << idx) : 4'hF;
        e.sseg = lit ? dec(m_disp_din[idx*4 +: 4]) : 7'h7F;
        e.dp   = lit ? ~m_disp_dp[idx] : 1'b1;
        e.fs   = (pre == 0) && (idx == 0);
        e.ack  = bnd && m_pending;
        exp_q.push_back(e);
        if (bnd && m_pending) begin
            m_disp_din = m_pend_din; m_disp_dp = m_pend_dp; m_disp_blank = m_pend_blank;
        end
        if (ld) begin
            m_pend_din = d; m_pend_dp = dpv; m_pend_blank = bl; m_pending = 1'b1;
        end else if (bnd) begin
            m_pending = 1'b0;
        end
        m_n++;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic run_idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(1'b0, 16'h0000, 4'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
        $fatal(1);
    end

    initial begin
        bus.load = 1'b0; bus.din = '0; bus.dp_in = '0; bus.blank_in = '0;
        bright = 3'd7; bus.brightness = bright;
        reset_n = 1'b0;
        model_reset();
        clear_counts();
        @(negedge clk);
        repeat (3) push_dark();
        reset_n = 1'b1;

        clear_counts();
        run_idle(200);                                 // n 0..199
        check("idle_frame_starts", fs_cnt, 4);
        check("idle_acks", ack_cnt, 0);

        clear_counts();
        cycle(1'b1, 16'h3210, 4'h0, 4'h0);             // n 200, commits at 255
        run_idle(119);                                 // n 201..319
        check("first_load_acks", ack_cnt, 1);

        bright = 3'd1;
        clear_counts();
        run_idle(64);                                  // n 320..383
        for (int k = 0; k < ND; k++)
            check($sformatf("dim_on_cycles_d%0d", k), low_cnt[k], 4);

        bright = 3'd7;
        clear_counts();
        run_idle(6);                                   // n 384..389
        cycle(1'b1, 16'h1111, 4'h0, 4'h0);             // n 390
        run_idle(9);                                   // n 391..399
        cycle(1'b1, 16'hABCD, 4'h0, 4'h0);             // n 400
        run_idle(46);                                  // n 401..446
        cycle(1'b1, 16'h5678, 4'h0, 4'h0);             // n 447, boundary load
        run_idle(128);                                 // n 448..575
        check("multi_load_acks", ack_cnt, 2);

        cycle(1'b1, 16'h3210, 4'b0001, 4'b0100);       // n 576, commits at 639
        run_idle(63);                                  // n 577..639
        clear_counts();
        run_idle(64);                                  // n 640..703
        check("dp_low_cycles", dp_low_cnt, 16);
        check("blanked_digit2_on", low_cnt[2], 0);
        check("digit0_on", low_cnt[0], 16);

        run_idle(21);                                  // n 704..724, slot 1
        check("pre_reset_an", bus.an, 4'b1101);
        #1 reset_n = 1'b0;
        #1;
        check("async_an", bus.an, 4'hF);
        check("async_sseg", bus.sseg, 7'h7F);
        check("async_dp", bus.dp, 1'b1);
        repeat (3) push_dark();
        model_reset();
        reset_n = 1'b1;

        clear_counts();
        run_idle(150);                                 // n 0..149
        check("post_reset_frame_starts", fs_cnt, 3);
        check("post_reset_acks", ack_cnt, 0);
        check("post_reset_dark", low_cnt[0] + low_cnt[1] + low_cnt[2] + low_cnt[3], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal 1..8.
REQ-002 Parameter SLOT_CYCLES, default 65536: clk cycles per digit slot, legal values are multiples of 8 and >= 8.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  4*NUM_DIGITS  hex value per digit; digit k is din[4k+3:4k].
REQ-006 dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-007 blank_in  input  NUM_DIGITS  per-digit blank, 1 = digit dark.
REQ-008 load  input  1  capture din/dp_in/blank_in into the pending buffer.
REQ-009 brightness  input  3  duty level 0..7, sampled every cycle.
REQ-010 an  output  NUM_DIGITS  digit enables, active-low, registered.
REQ-011 sseg  output  7  segments {a,b,c,d,e,f,g}, active-low, registered.
REQ-012 dp  output  1  decimal point, active-low, registered.
REQ-013 frame_start  output  1  one-cycle pulse when scanning returns to digit 0.
REQ-014 load_ack  output  1  one-cycle pulse when the pending buffer commits to the display.

Function
REQ-015 The prescaler shall count 0..SLOT_CYCLES-1 and wrap; at the wrap, the digit index shall advance 0..NUM_DIGITS-1 and wrap to 0.
REQ-016 The frame boundary shall be the prescaler wrap while the index is NUM_DIGITS-1.
REQ-017 load=1 shall copy din, dp_in and blank_in into the pending registers on that edge and set the pending flag; when several loads occur in one frame, the last load wins.
REQ-018 At the frame boundary with pending=1, the pending registers shall move to the display registers, pending shall clear, and load_ack shall pulse for one cycle.
REQ-019 load coincident with the boundary: the commit shall use the old pending contents; the new values shall land in pending with pending=1, for commit at the next boundary.
REQ-020 The display registers shall never change except at a frame boundary, so no frame is torn.
REQ-021 frame_start shall pulse one cycle, aligned with the first output cycle of digit 0, on every frame regardless of load.
REQ-022 On-window: a digit shall be enabled only while prescaler < (brightness+1)*(SLOT_CYCLES/8); brightness=7 gives the full slot, and brightness=0 gives 1/8.
REQ-023 Active digit k: an[k]=0 and all other an bits=1 when in the on-window and blank[k]=0; otherwise an shall be all ones.
REQ-024 Active digit k: sseg shall be the decode of digit k and dp = ~dp[k]; when an is all ones, sseg shall be 7'b1111111 and dp=1.
REQ-025 Decode 0..F: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-026 Outputs shall be registered with one cycle of latency from the prescaler/index state they reflect.
REQ-027 The counter widths shall be clog2-derived from the parameters and shall be free of overflow at the maximum legal values.

Reset
REQ-028 reset_n=0 shall force, asynchronously, an all ones, sseg=7'b1111111, dp=1, frame_start=0 and load_ack=0.
REQ-029 Reset shall clear the prescaler, index and pending flag, set the display and pending blank bits to all ones, and zero the digit and dp registers.
REQ-030 Reset asserted mid-frame shall discard pending data; after release, scanning shall restart at digit 0, prescaler 0, and stay dark until the first commit.

Verification (NUM_DIGITS=4, SLOT_CYCLES=16)
REQ-031 Reset then idle 200 cycles -> an=1111, sseg=1111111, dp=1 throughout; frame_start pulses every 64 cycles.
REQ-032 load din=16'h3210, blank=0000, brightness=7 -> load_ack at the next boundary; an cycles 1110/1101/1011/0111 with 16 cycles each; sseg 0000001/1001111/0010010/0000110.
REQ-033 brightness=1 -> each an bit is low exactly 4 of 16 cycles per slot, at prescaler 0..3.
REQ-034 Two loads in one frame (16'h1111, then 16'hABCD), plus a load on the boundary cycle -> one ack per boundary; hABCD is shown the next frame, the boundary value the frame after.
REQ-035 blank=0100, dp_in=0001 -> an[2] stays 1 during slot 2; dp=0 only during slot 0.
REQ-036 reset_n pulsed low mid-slot 1 -> outputs go dark without waiting for clk; restart from digit 0 and stay blank.
